// File: rtl/sequential_multiplier.sv
// sequential_multiplier: radix-2 shift-add RV32M multiplier (MUL/MULH/MULHSU/MULHU), one bit per cycle.
// Define MUL_ZERO_EARLY_OUT_EN to skip the iteration when either operand is zero.
module sequential_multiplier #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] multiplicand,
  input  logic [WIDTH-1:0] multiplier,
  output logic [WIDTH-1:0] result,
  output logic             busy,
  output logic             done
);
  localparam int CW = $clog2(WIDTH) + 1;
`ifdef MUL_ZERO_EARLY_OUT_EN
  localparam bit EARLY_OUT = 1'b1;
`else
  localparam bit EARLY_OUT = 1'b0;
`endif
  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;
  state_t state_q, state_d;
  logic [1:0] op_q, op_d;
  logic neg_q, neg_d, done_q, done_d;
  logic [WIDTH-1:0] mcand_q, mcand_d, result_q, result_d;
  logic [2*WIDTH-1:0] prod_q, prod_d, prod_fin;
  logic [CW-1:0] cnt_q, cnt_d;
  logic a_neg, b_neg, zero;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0] sum;
  // rs1 is signed for MULH/MULHSU, rs2 only for MULH
  assign a_neg = (op[1] ^ op[0]) & multiplicand[WIDTH-1];
  assign b_neg = (op == 2'b01) & multiplier[WIDTH-1];
  assign a_mag = a_neg ? -multiplicand : multiplicand;
  assign b_mag = b_neg ? -multiplier : multiplier;
  assign zero = EARLY_OUT && (multiplicand == '0 || multiplier == '0);
  assign sum = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
  assign prod_fin = neg_q ? -prod_q : prod_q;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      op_q     <= '0;
      neg_q    <= 1'b0;
      mcand_q  <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      mcand_q  <= mcand_d;
      prod_q   <= prod_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end
  always_comb begin
    state_d = state_q == IDLE ? (start ? (zero ? FINISH : RUN) : IDLE)
            : state_q == RUN  ? (cnt_q == CW'(WIDTH-1) ? FINISH : RUN)
            : IDLE;
  end
  always_comb begin
    op_d     = op_q;
    neg_d    = neg_q;
    mcand_d  = mcand_q;
    prod_d   = prod_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        op_d    = op;
        neg_d   = a_neg ^ b_neg;
        mcand_d = a_mag;
        prod_d  = {{WIDTH{1'b0}}, zero ? {WIDTH{1'b0}} : b_mag};
        cnt_d   = '0;
      end
      RUN: begin
        prod_d = {sum, prod_q[WIDTH-1:1]};
        cnt_d  = cnt_q + CW'(1);
      end
      FINISH: begin
        result_d = op_q == 2'b00 ? prod_fin[WIDTH-1:0] : prod_fin[2*WIDTH-1:WIDTH];
        done_d   = 1'b1;
      end
      default: ;
    endcase
  end
  always_comb begin
    busy   = state_q != IDLE;
    done   = done_q;
    result = result_q;
  end
endmodule

// File: tb/tb_sequential_multiplier.sv
// tb_sequential_multiplier: scoreboard bench; expected results and done cycles queued at issue, checked by a monitor.
module tb_sequential_multiplier;
  logic clk = 1'b0, reset_n = 1'b0, start = 1'b0;
  logic [1:0] op = '0;
  logic [31:0] a = '0, b = '0;
  logic [31:0] result;
  logic busy, done;
  int cyc = 0, checks = 0, errors = 0;
  typedef struct {logic [31:0] r; int c;} exp_t;
  typedef struct {logic [1:0] o; logic [31:0] x, y, e;} vec_t;
  exp_t q[$];
  exp_t mon_e;
  vec_t vecs[12] = '{
    '{2'd0, 32'h00000007, 32'h00000006, 32'h0000002A},
    '{2'd1, 32'h80000000, 32'h80000000, 32'h40000000},
    '{2'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE},
    '{2'd2, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF},
    '{2'd0, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFF1},
    '{2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000},
    '{2'd3, 32'h80000000, 32'h00000002, 32'h00000001},
    '{2'd1, 32'h7FFFFFFF, 32'h80000000, 32'hC0000000},
    '{2'd2, 32'h80000000, 32'hFFFFFFFF, 32'h80000000},
    '{2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001},
    '{2'd2, 32'h00000002, 32'hFFFFFFFF, 32'h00000001},
    '{2'd0, 32'h00000000, 32'h12345678, 32'h00000000}
  };

  sequential_multiplier #(.WIDTH(32)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .op(op),
    .multiplicand(a), .multiplier(b), .result(result), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int lat(logic [31:0] x, logic [31:0] y);
`ifdef MUL_ZERO_EARLY_OUT_EN
    if (x == 0 || y == 0) return 2;
`endif
    return 34;
  endfunction

  function automatic logic [31:0] ref_mul(logic [1:0] o, logic [31:0] x, logic [31:0] y);
    logic signed [65:0] sx, sy, p;
    sx = {{34{(o == 2'd1 || o == 2'd2) & x[31]}}, x};
    sy = {{34{(o == 2'd1) & y[31]}}, y};
    p = sx * sy;
    return o == 2'd0 ? p[31:0] : p[63:32];
  endfunction

  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  task automatic wait_idle();
    int t = 0;
    @(negedge clk);
    while (busy && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("wait_idle_busy", {31'b0, busy}, 32'd0);
  endtask

  task automatic issue(logic [1:0] o, logic [31:0] x, logic [31:0] y, logic [31:0] e);
    wait_idle();
    op = o; a = x; b = y; start = 1'b1;
    q.push_back('{e, cyc + lat(x, y)});
    @(negedge clk);
    start = 1'b0;
    op = 2'($urandom); a = $urandom; b = $urandom;
  endtask

  always @(negedge clk) if (reset_n && done) begin
    checks++;
    if (busy) begin
      errors++;
      $display("FAIL busy_with_done: got busy=1 expected 0");
    end
    checks++;
    if (q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_done: got done=1 at cycle %0d expected none", cyc);
    end else begin
      mon_e = q.pop_front();
      checks++;
      if (result !== mon_e.r) begin
        errors++;
        $display("FAIL result: got %h expected %h", result, mon_e.r);
      end
      checks++;
      if (cyc != mon_e.c) begin
        errors++;
        $display("FAIL done_cycle: got %0d expected %0d", cyc, mon_e.c);
      end
    end
  end

  initial begin
    int t;
    repeat (2) @(negedge clk);
    chk("rst_result", result, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    reset_n = 1'b1;
    foreach (vecs[i]) issue(vecs[i].o, vecs[i].x, vecs[i].y, vecs[i].e);
    // start pulsed mid-RUN must be dropped without disturbing the running op
    issue(2'd0, 32'h00001234, 32'h00000010, 32'h00012340);
    repeat (5) @(negedge clk);
    chk("busy_in_run", {31'b0, busy}, 32'd1);
    op = 2'd3; a = 32'hDEADBEEF; b = 32'h0BADF00D; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    // second op launched in the done cycle
    issue(2'd3, 32'h00010000, 32'h00010000, 32'h00000001);
    t = 0;
    while (busy && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("b2b_done_seen", {31'b0, done}, 32'd1);
    op = 2'd0; a = 32'hFFFFFFFF; b = 32'h00000003; start = 1'b1;
    q.push_back('{32'hFFFFFFFD, cyc + 34});
    @(negedge clk);
    start = 1'b0;
    chk("b2b_accept", {31'b0, busy}, 32'd1);
    // reset roughly ten cycles into RUN
    issue(2'd2, 32'h00000005, 32'h00000003, 32'h00000000);
    repeat (9) @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("midrst_result", result, 32'd0);
    chk("midrst_busy", {31'b0, busy}, 32'd0);
    chk("midrst_done", {31'b0, done}, 32'd0);
    q.delete();
    @(negedge clk);
    reset_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("postrst_busy", {31'b0, busy}, 32'd0);
    issue(2'd0, 32'h00000000, 32'h12345678, 32'h00000000);
    issue(2'd3, 32'h9ABCDEF0, 32'h00000000, 32'h00000000);
    for (int o = 0; o < 4; o++)
      for (int k = 0; k < 25; k++) begin
        logic [31:0] x, y;
        x = $urandom; y = $urandom;
        issue(2'(o), x, y, ref_mul(2'(o), x, y));
      end
    t = 0;
    while (q.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("drain_pending", q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
